// File: rtl/tw_cmul_stream_if.sv
// Sample stream bundle shared by the input and output sides of tw_cmul_stream.
//   valid : sample qualifier
//   sop   : first sample of a frame, meaningful only while valid=1
//   re/im : signed complex sample, W bits each
// master drives the stream, slave receives it.
interface tw_cmul_stream_if #(
   parameter int unsigned W = 16
);
   logic                valid;
   logic                sop;
   logic signed [W-1:0] re;
   logic signed [W-1:0] im;

   modport master (output valid, output sop, output re, output im);
   modport slave  (input  valid, input  sop, input  re, input  im);
endinterface

// File: rtl/tw_cmul_stream.sv
// Streaming twiddle-multiply stage.
// Issues a twiddle ROM read (enable + angle pointer) for every accepted input sample, lines the
// sample up with the ROM's one-cycle registered data, forms the complex product, then rounds
// and saturates. Fixed 3-cycle latency from an accepted sample to its output, no backpressure.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_i            : input sample stream (slave)
//   en_rd_o         : ROM read enable, equals in_i.valid
//   rd_ptr_angle_o  : ROM angle index (0 on sop, else running counter)
//   cos_data_i      : ROM real twiddle, Q2.12, one cycle after en_rd_o
//   sin_data_i      : ROM imaginary twiddle (already -sin), Q2.12, one cycle after en_rd_o
//   out_o           : output sample stream (master)
module tw_cmul_stream #(
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned word_length    = 16,
   parameter int unsigned word_length_tw = 14,
   parameter int unsigned TW_FRAC        = 12
) (
   input  logic                             clk,
   input  logic                             rst_n,
   tw_cmul_stream_if.slave                  in_i,
   output logic                             en_rd_o,
   output logic        [ADDR_W-1:0]         rd_ptr_angle_o,
   input  logic signed [word_length_tw-1:0] cos_data_i,
   input  logic signed [word_length_tw-1:0] sin_data_i,
   tw_cmul_stream_if.master                 out_o
);

   localparam int unsigned PW = word_length + word_length_tw;  // product width
   localparam int unsigned SW = PW + 1;                        // sum/difference width

   localparam logic signed [SW-1:0] RndHalf = SW'(1) <<< (TW_FRAC - 1);
   localparam logic signed [SW-1:0] SatMax  = (SW'(1) <<< (word_length - 1)) - SW'(1);
   localparam logic signed [SW-1:0] SatMin  = ~SatMax;

   function automatic logic signed [word_length-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SatMax) begin
         return SatMax[word_length-1:0];
      end else if (v < SatMin) begin
         return SatMin[word_length-1:0];
      end
      return v[word_length-1:0];
   endfunction

   // Angle counter
   logic [ADDR_W-1:0] cnt_q, cnt_d, rd_ptr;

   always_comb begin
      rd_ptr = in_i.sop ? '0 : cnt_q;
      // sop takes priority over wrap: pointer 0, counter moves on to 1
      cnt_d  = in_i.valid ? rd_ptr + 1'b1 : cnt_q;
   end

   assign en_rd_o        = in_i.valid;
   assign rd_ptr_angle_o = rd_ptr;

   // S1: sample registered while the ROM word for it is being read
   logic                          vld1_q, sop1_q;
   logic signed [word_length-1:0] a_q, b_q;
   // S2: partial products
   logic                          vld2_q, sop2_q;
   logic signed [PW-1:0]          ac_q, bd_q, ad_q, bc_q;
   logic signed [PW-1:0]          ac_d, bd_d, ad_d, bc_d;
   // S3: rounded, saturated result
   logic                          vld3_q, sop3_q;
   logic signed [word_length-1:0] re_q, im_q, re_d, im_d;
   logic signed [SW-1:0]          re_sum, im_sum, re_rnd, im_rnd;

   always_comb begin
      ac_d = PW'(a_q) * PW'(cos_data_i);
      bd_d = PW'(b_q) * PW'(sin_data_i);
      ad_d = PW'(a_q) * PW'(sin_data_i);
      bc_d = PW'(b_q) * PW'(cos_data_i);
   end

   always_comb begin
      re_sum = SW'(ac_q) - SW'(bd_q);
      im_sum = SW'(ad_q) + SW'(bc_q);
      re_rnd = (re_sum + RndHalf) >>> TW_FRAC;
      im_rnd = (im_sum + RndHalf) >>> TW_FRAC;
      re_d   = sat(re_rnd);
      im_d   = sat(im_rnd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         vld1_q <= 1'b0;
         sop1_q <= 1'b0;
         vld2_q <= 1'b0;
         sop2_q <= 1'b0;
         vld3_q <= 1'b0;
         sop3_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         ac_q   <= '0;
         bd_q   <= '0;
         ad_q   <= '0;
         bc_q   <= '0;
         re_q   <= '0;
         im_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         // Qualifier pipeline free-runs; sop is kept only alongside a valid sample
         vld1_q <= in_i.valid;
         sop1_q <= in_i.valid & in_i.sop;
         vld2_q <= vld1_q;
         sop2_q <= sop1_q;
         vld3_q <= vld2_q;
         sop3_q <= sop2_q;
         if (in_i.valid) begin
            a_q <= in_i.re;
            b_q <= in_i.im;
         end
         if (vld1_q) begin
            ac_q <= ac_d;
            bd_q <= bd_d;
            ad_q <= ad_d;
            bc_q <= bc_d;
         end
         if (vld2_q) begin
            re_q <= re_d;
            im_q <= im_d;
         end
      end
   end

   assign out_o.valid = vld3_q;
   assign out_o.sop   = sop3_q;
   assign out_o.re    = re_q;
   assign out_o.im    = im_q;

endmodule

// File: tb/tb_tw_cmul_stream.sv
// Self-checking bench for tw_cmul_stream: directed test-plan steps plus a randomized phase,
// all checked against a cycle-indexed scoreboard built from plain integer arithmetic.
module tb_tw_cmul_stream;

   localparam int N = 128;

   logic clk;
   logic rst_n;
   logic              en_rd;
   logic [6:0]        rd_ptr;
   logic signed [13:0] cos_q, sin_q;

   tw_cmul_stream_if #(.W(16)) s_in ();
   tw_cmul_stream_if #(.W(16)) s_out ();

   tw_cmul_stream #(
      .ADDR_W         (7),
      .word_length    (16),
      .word_length_tw (14),
      .TW_FRAC        (12)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_i           (s_in.slave),
      .en_rd_o        (en_rd),
      .rd_ptr_angle_o (rd_ptr),
      .cos_data_i     (cos_q),
      .sin_data_i     (sin_q),
      .out_o          (s_out.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ROM: cos_k = round(4096 cos(k*pi/128)), sin_k = -round(4096 sin(k*pi/128))
   int rom_c [N];
   int rom_s [N];

   always @(posedge clk) begin
      if (en_rd) begin
         cos_q <= 14'(rom_c[rd_ptr]);
         sin_q <= 14'(rom_s[rd_ptr]);
      end
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned        cyc;
      logic               sop;
      logic signed [15:0] re;
      logic signed [15:0] im;
   } exp_t;

   exp_t q[$];
   int   m_cnt = 0;
   int   ntest = 0;
   int   nfail = 0;

   function automatic int rnd(real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   // round-half-up by 2^12 then clamp to 16-bit signed
   function automatic logic signed [15:0] scale(longint p);
      longint r;
      r = (p + 2048) >>> 12;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      ntest++;
      assert (got === exp)
      else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_out();
      if (q.size() > 0 && q[0].cyc == cyc) begin
         chk("out_valid", 32'(s_out.valid), 1);
         chk("out_sop", 32'(s_out.sop), 32'(q[0].sop));
         chk("out_re", s_out.re, q[0].re);
         chk("out_im", s_out.im, q[0].im);
         void'(q.pop_front());
      end else begin
         chk("out_valid_idle", 32'(s_out.valid), 0);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic signed [15:0] re,
                       input logic signed [15:0] im);
      int   ptr;
      exp_t e;
      @(negedge clk);
      check_out();
      s_in.valid = v;
      s_in.sop   = s;
      s_in.re    = re;
      s_in.im    = im;
      #1;
      chk("en_rd", 32'(en_rd), 32'(v));
      if (v) begin
         ptr = s ? 0 : m_cnt;
         chk("rd_ptr", 32'(rd_ptr), ptr);
         e.cyc = cyc + 3;
         e.sop = s;
         e.re  = scale(longint'(re) * rom_c[ptr] - longint'(im) * rom_s[ptr]);
         e.im  = scale(longint'(re) * rom_s[ptr] + longint'(im) * rom_c[ptr]);
         q.push_back(e);
         m_cnt = (ptr + 1) % N;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'sd0, 16'sd0);
   endtask

   task automatic chk_zero_out(input string tag);
      chk({tag, "_valid"}, 32'(s_out.valid), 0);
      chk({tag, "_sop"}, 32'(s_out.sop), 0);
      chk({tag, "_re"}, s_out.re, 0);
      chk({tag, "_im"}, s_out.im, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      s_in.valid = 1'b0;
      s_in.sop   = 1'b0;
      #1;
      chk_zero_out("rst_async");
      q.delete();
      m_cnt = 0;
      @(negedge clk);
      chk_zero_out("rst_hold");
      rst_n = 1'b1;
   endtask

   function automatic logic signed [15:0] rand_word();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 16'sh7fff;
      if (sel == 1) return 16'sh8000;
      return 16'($urandom);
   endfunction

   initial begin
      real pi;
      logic v, s;
      pi = 3.14159265358979;
      for (int k = 0; k < N; k++) begin
         rom_c[k] = rnd(4096.0 * $cos(k * pi / 128.0));
         rom_s[k] = -rnd(4096.0 * $sin(k * pi / 128.0));
      end

      rst_n      = 1'b0;
      s_in.valid = 1'b0;
      s_in.sop   = 1'b0;
      s_in.re    = '0;
      s_in.im    = '0;
      @(negedge clk);
      @(negedge clk);
      chk_zero_out("reset");
      rst_n = 1'b1;

      // Full frame of constant 1000 + j0
      for (int k = 0; k < N; k++) step(1'b1, k == 0, 16'sd1000, 16'sd0);
      idle(4);

      // Saturation at index 96 (counter wrapped back to 0 after the frame)
      for (int k = 0; k <= 96; k++) begin
         if (k == 96) step(1'b1, 1'b0, 16'sd32767, -16'sd32767);
         else step(1'b1, 1'b0, rand_word(), rand_word());
      end
      idle(4);

      // Rounding at index 0 and index 32
      step(1'b1, 1'b1, 16'sd1, 16'sd0);
      for (int k = 1; k < 32; k++) step(1'b1, 1'b0, rand_word(), rand_word());
      step(1'b1, 1'b0, 16'sd3, 16'sd0);
      idle(4);

      // Gapped input 1,0,0,1,1
      step(1'b1, 1'b1, 16'sd500, -16'sd700);
      idle(2);
      step(1'b1, 1'b0, -16'sd1234, 16'sd4321);
      step(1'b1, 1'b0, 16'sd32767, 16'sd32767);
      idle(4);

      // Wrap over 130 samples, then sop at counter 50
      for (int k = 0; k < 130; k++) step(1'b1, k == 0, rand_word(), rand_word());
      for (int k = 0; k < 48; k++) step(1'b1, 1'b0, rand_word(), rand_word());
      step(1'b1, 1'b1, rand_word(), rand_word());
      step(1'b1, 1'b0, rand_word(), rand_word());
      idle(4);

      // Randomized valid gaps, sop and data
      for (int k = 0; k < 300; k++) begin
         v = ($urandom_range(0, 9) < 7);
         s = v && ($urandom_range(0, 29) == 0);
         step(v, s, rand_word(), rand_word());
      end
      idle(4);

      // Reset mid-frame with samples in flight
      for (int k = 0; k < 40; k++) step(1'b1, k == 0, rand_word(), rand_word());
      do_reset();
      idle(4);
      step(1'b1, 1'b0, 16'sd1000, 16'sd0);
      step(1'b1, 1'b0, rand_word(), rand_word());
      idle(5);

      chk("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
